// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer between the control unit and a byte-addressed data memory.
// Each request is range/alignment checked, then issued as timed strobes.
module mem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_w,
  output logic        mem_r,
  output logic        mem_s,
  output logic [1:0]  mem_c,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [32:0] LAST_OFFSET = 33'(DEPTH - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_c_q, mem_c_d;
  logic        mem_s_q, mem_s_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  req_c;
  logic [32:0] req_bytes;
  logic [31:0] req_offset;
  logic [32:0] req_end;
  logic        req_bad;
  logic        op_is_store;

  // Request decode: size, offset and the 33-bit end address so a CPU address
  // below BASE_ADDR wraps to a huge offset and fails the range test.
  always_comb begin
    req_c     = 2'b00;
    req_bytes = 33'd4;
    case (op)
      OP_LH, OP_LHU, OP_SH: begin req_c = 2'b01; req_bytes = 33'd2; end
      OP_LB, OP_LBU, OP_SB: begin req_c = 2'b10; req_bytes = 33'd1; end
      default:              begin req_c = 2'b00; req_bytes = 33'd4; end
    endcase
    req_offset = addr - BASE_ADDR;
    req_end    = {1'b0, req_offset} + req_bytes - 33'd1;
    req_bad    = (req_end > LAST_OFFSET)
               || ((req_c == 2'b00) && (addr[1:0] != 2'b00))
               || ((req_c == 2'b01) && addr[0]);
  end

  assign op_is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mem_addr_d  = mem_addr_q;
    mem_c_d     = mem_c_q;
    mem_s_d     = mem_s_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_bad) begin
            state_d = S_FAULT;
          end else begin
            state_d     = S_SETUP;
            op_d        = op;
            mem_addr_d  = req_offset;
            mem_c_d     = req_c;
            mem_s_d     = (op == OP_LH) || (op == OP_LB);
            mem_wdata_d = wdata;
          end
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: state_d = op_is_store ? S_DONE : S_CAPTURE;
      S_CAPTURE: begin
        state_d = S_DONE;
        case (op_q)
          OP_LH:   rdata_d = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
          OP_LHU:  rdata_d = {16'h0000, mem_rdata[15:0]};
          OP_LB:   rdata_d = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
          OP_LBU:  rdata_d = {24'h000000, mem_rdata[7:0]};
          default: rdata_d = mem_rdata;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      mem_addr_q  <= '0;
      mem_c_q     <= 2'b00;
      mem_s_q     <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mem_addr_q  <= mem_addr_d;
      mem_c_q     <= mem_c_d;
      mem_s_q     <= mem_s_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Strobes decode straight from state, so a reset drops them at the next edge.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_FAULT);
  assign mem_w     = (state_q == S_ACCESS) && op_is_store;
  assign mem_r     = ((state_q == S_ACCESS) || (state_q == S_CAPTURE)) && !op_is_store;
  assign mem_s     = mem_s_q;
  assign mem_c     = mem_c_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small byte-addressed memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, fault, mem_w, mem_r, mem_s;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_c;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [0:1023];

  // Observations of one transaction
  int          done_cyc, fault_cyc, done_cnt, fault_cnt, w_cnt, r_cnt, busy_cnt, both_cnt;
  logic [31:0] w_addr;
  logic [1:0]  w_c;
  logic        s_seen;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .mem_w(mem_w), .mem_r(mem_r), .mem_s(mem_s), .mem_c(mem_c),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = 32'h0;
    case (mem_c)
      2'b00: mem_rdata = {mem[(mem_addr[9:0] + 10'd3)], mem[(mem_addr[9:0] + 10'd2)],
                          mem[(mem_addr[9:0] + 10'd1)], mem[mem_addr[9:0]]};
      2'b01: mem_rdata = {16'h0, mem[(mem_addr[9:0] + 10'd1)], mem[mem_addr[9:0]]};
      default: mem_rdata = {24'h0, mem[mem_addr[9:0]]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_w) begin
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_c != 2'b10) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_c == 2'b00) begin
        mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and observe 8 cycles after acceptance; optionally
  // re-pulse start during SETUP (cycle 1) and CAPTURE (cycle 3).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input bit restart);
    done_cyc = 0; fault_cyc = 0; done_cnt = 0; fault_cnt = 0;
    w_cnt = 0; r_cnt = 0; busy_cnt = 0; both_cnt = 0;
    w_addr = 32'hFFFF_FFFF; w_c = 2'b11; s_seen = 1'b0;
    op = o; addr = a; wdata = wd; start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = k; end
      if (fault) begin fault_cnt++; if (fault_cyc == 0) fault_cyc = k; end
      if (mem_w) begin w_cnt++; w_addr = mem_addr; w_c = mem_c; end
      if (mem_r) r_cnt++;
      if (mem_w && mem_r) both_cnt++;
      if (busy) busy_cnt++;
      if (k == 1) s_seen = mem_s;
      start = restart && (k == 1 || k == 3);
    end
    $display("[TB] op=%0d addr=%08h done@%0d fault@%0d w=%0d r=%0d busy=%0d rdata=%08h",
             o, a, done_cyc, fault_cyc, w_cnt, r_cnt, busy_cnt, rdata);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[32'h20] = 8'hF0; mem[32'h21] = 8'h80; mem[32'h22] = 8'h00; mem[32'h23] = 8'h00;
    rst = 1'b1; start = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_fault", {30'd0, done, fault}, 32'd0);
    check("rst_strobes", {29'd0, mem_w, mem_r, mem_s}, 32'd0);
    check("rst_mem_c", {30'd0, mem_c}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);

    // Word store then load
    run_op(3'b101, 32'h10010008, 32'hDEADBEEF, 1'b0);
    check("sw_done_cyc", done_cyc, 32'd3);
    check("sw_w_cnt", w_cnt, 32'd1);
    check("sw_w_addr", w_addr, 32'd8);
    check("sw_w_c", {30'd0, w_c}, 32'd0);
    check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_no_read", r_cnt, 32'd0);
    run_op(3'b000, 32'h10010008, 32'h0, 1'b0);
    check("lw_done_cyc", done_cyc, 32'd4);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    check("lw_r_cnt", r_cnt, 32'd2);
    check("lw_no_write", w_cnt, 32'd0);

    // Extension of memory value 0x000080F0
    run_op(3'b011, 32'h10010020, 32'h0, 1'b0);
    check("lb_rdata", rdata, 32'hFFFFFFF0);
    check("lb_mem_s", {31'd0, s_seen}, 32'd1);
    run_op(3'b100, 32'h10010020, 32'h0, 1'b0);
    check("lbu_rdata", rdata, 32'h000000F0);
    check("lbu_mem_s", {31'd0, s_seen}, 32'd0);
    run_op(3'b001, 32'h10010020, 32'h0, 1'b0);
    check("lh_rdata", rdata, 32'hFFFF80F0);
    check("lh_mem_s", {31'd0, s_seen}, 32'd1);
    check("lh_mem_c", {30'd0, mem_c}, 32'd1);
    run_op(3'b010, 32'h10010020, 32'h0, 1'b0);
    check("lhu_rdata", rdata, 32'h000080F0);
    check("lhu_mem_s", {31'd0, s_seen}, 32'd0);

    // Alignment
    run_op(3'b000, 32'h10010002, 32'h0, 1'b0);
    check("lw_mis_fault_cyc", fault_cyc, 32'd1);
    check("lw_mis_fault_cnt", fault_cnt, 32'd1);
    check("lw_mis_strobes", w_cnt + r_cnt, 32'd0);
    check("lw_mis_no_done", done_cnt, 32'd0);
    check("lw_mis_rdata_kept", rdata, 32'h000080F0);
    run_op(3'b110, 32'h10010001, 32'h1234, 1'b0);
    check("sh_mis_fault_cyc", fault_cyc, 32'd1);
    check("sh_mis_strobes", w_cnt + r_cnt, 32'd0);
    run_op(3'b111, 32'h10010003, 32'h000000A5, 1'b0);
    check("sb_done_cyc", done_cyc, 32'd3);
    check("sb_w_c", {30'd0, w_c}, 32'd2);
    run_op(3'b100, 32'h10010003, 32'h0, 1'b0);
    check("sb_readback", rdata, 32'h000000A5);

    // Range
    run_op(3'b101, 32'h100103FC, 32'h12345678, 1'b0);
    check("sw_top_done_cyc", done_cyc, 32'd3);
    check("sw_top_w_addr", w_addr, 32'd1020);
    run_op(3'b000, 32'h100103FC, 32'h0, 1'b0);
    check("lw_top_done_cyc", done_cyc, 32'd4);
    check("lw_top_rdata", rdata, 32'h12345678);
    run_op(3'b000, 32'h100103FE, 32'h0, 1'b0);
    check("lw_3fe_fault_cyc", fault_cyc, 32'd1);
    run_op(3'b001, 32'h10010400, 32'h0, 1'b0);
    check("lh_400_fault_cyc", fault_cyc, 32'd1);
    check("lh_400_strobes", w_cnt + r_cnt, 32'd0);
    run_op(3'b000, 32'h1000FFFC, 32'h0, 1'b0);
    check("lw_wrap_fault_cyc", fault_cyc, 32'd1);
    check("lw_wrap_rdata_kept", rdata, 32'h12345678);

    // Restart pulses while busy are ignored
    run_op(3'b000, 32'h10010008, 32'h0, 1'b1);
    check("restart_done_cnt", done_cnt, 32'd1);
    check("restart_done_cyc", done_cyc, 32'd4);
    check("restart_busy_cnt", busy_cnt, 32'd4);
    check("restart_rdata", rdata, 32'hDEADBEEF);
    check("restart_no_overlap", both_cnt, 32'd0);

    // Reset during ACCESS of a store
    op = 3'b101; addr = 32'h10010010; wdata = 32'h00000055; start = 1'b1;
    @(negedge clk); start = 1'b0;          // SETUP
    @(negedge clk);                        // ACCESS
    check("rstmid_in_access_w", {31'd0, mem_w}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_mem_w", {31'd0, mem_w}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || fault) done_cnt++;
    end
    check("rstmid_no_done", done_cnt, 32'd0);
    check("rstmid_rdata_cleared", rdata, 32'd0);
    run_op(3'b000, 32'h10010008, 32'h0, 1'b0);
    check("post_rst_lw_done_cyc", done_cyc, 32'd4);
    check("post_rst_lw_rdata", rdata, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multicycle load/store sequencer between the control unit/datapath and the byte-addressed data memory (DMEM).
- Accepts one load/store request and translates the CPU address into a memory offset.
- Checks alignment and range, drives the memory control lines (write/read/sign/size) as timed pulses, then latches and extends the read data into a memory data register.
- Reports done or fault back to the control unit.

Parameters:
- BASE_ADDR, 32'h10010000, CPU address mapped to memory byte offset 0.
- DEPTH, 1024, memory size in bytes; valid offsets are 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- addr  in  32  CPU byte address.
- wdata  in  32  store data; low bits used for SH/SB.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the access completes.
- fault  out  1  one-cycle pulse on a misaligned or out-of-range request.
- rdata  out  32  memory data register, extended load result.
- mem_w  out  1  memory write strobe.
- mem_r  out  1  memory read enable.
- mem_s  out  1  signed-load flag.
- mem_c  out  2  access size: 00 word, 01 half, 10 byte.
- mem_addr  out  32  byte offset, equal to addr - BASE_ADDR.
- mem_wdata  out  32  store data to memory.
- mem_rdata  in  32  memory read data, right-justified and valid combinationally while mem_r is high.

Behaviour:
- Reset: state IDLE. busy, done, fault, mem_w, mem_r, mem_s are 0. mem_c=00, mem_addr=0, mem_wdata=0, rdata=0. rst mid-operation aborts the access; all strobes are low from the next edge and no done or fault is issued.
- States: IDLE, SETUP, ACCESS, CAPTURE, DONE, FAULT.
- IDLE: when start=1, register op, the offset (addr-BASE_ADDR) and wdata. Go to SETUP, or to FAULT if the check fails. start=0 stays in IDLE.
- Fault check:
  - Word requires addr[1:0]=00; half requires addr[0]=0.
  - The range rule is offset+size-1 <= DEPTH-1, computed in 33 bits so that addr < BASE_ADDR wraps to a large offset and faults.
- SETUP (1 cycle): drive mem_addr, mem_c, mem_s and mem_wdata; mem_w=mem_r=0. This settles address and size before any strobe.
- ACCESS (1 cycle):
  - Store: mem_w=1 for exactly this cycle, then go to DONE.
  - Load: mem_r=1, go to CAPTURE.
- CAPTURE (1 cycle): mem_r stays 1. On the exiting edge, rdata is loaded:
  - LW: mem_rdata.
  - LH: sign-extend mem_rdata[15:0]. LHU: zero-extend mem_rdata[15:0].
  - LB: sign-extend mem_rdata[7:0]. LBU: zero-extend mem_rdata[7:0].
  - Then go to DONE.
- DONE: done=1 for one cycle, all strobes low, return to IDLE. start is not sampled in DONE.
- FAULT: fault=1 for one cycle, mem_w/mem_r never asserted, rdata unchanged, return to IDLE.
- Latency from the start edge:
  - Store: done is high in the 3rd cycle after acceptance.
  - Load: done is high in the 4th cycle after acceptance.
  - Fault: fault is high in the 1st cycle after acceptance.
- Field holding and start handling:
  - mem_addr, mem_c, mem_s and mem_wdata hold their last values outside an access.
  - rdata holds until the next successful load.
  - start while busy is ignored and not queued.
- mem_s=1 only for LH and LB; mem_c is derived from op.
- mem_wdata carries wdata unmodified; the memory selects the low half or byte.
- mem_w and mem_r are never high in the same cycle and are only asserted from the ACCESS/CAPTURE states.

Test Plan:
- Store then load, word: SW addr=0x10010008, wdata=0xDEADBEEF. mem_w is high exactly 1 cycle with mem_addr=8 and mem_c=00, done on cycle 3. LW from the same address gives rdata=0xDEADBEEF, done on cycle 4.
- Extension: memory returns 0x000080F0.
  - LB gives 0xFFFFFFF0; LBU gives 0x000000F0.
  - LH gives 0xFFFF80F0; LHU gives 0x000080F0.
  - mem_s is 1 only for LB and LH.
- Alignment: LW addr=0x10010002 and SH addr=0x10010001 each pulse fault 1 cycle after start, with no mem_w/mem_r pulse and rdata unchanged. SB addr=0x10010003 succeeds.
- Range:
  - LW addr=0x100103FC succeeds (offset 1020).
  - LW addr=0x100103FE faults on alignment.
  - LH addr=0x10010400 faults.
  - LW addr=0x1000FFFC faults via wraparound.
- Busy/restart: pulse start again during SETUP and CAPTURE; it is ignored, exactly one done is issued, and busy=1 from acceptance through DONE.
- Reset mid-operation: assert rst during ACCESS of an SW. Next cycle mem_w=0, state IDLE, done never pulses. A following LW works normally.
